// File: rtl/uart_pkg.sv
// Shared types and constants for the host-side autobaud UART.
package uart_pkg;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  typedef enum logic [1:0] {
    TX_GAP,
    TX_SYNC,
    TX_IDLE,
    TX_SEND
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_HUNT,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_host_rx.sv
// 8N1 receiver: 2-FF synchronizer, mid-bit sampling, glitch rejection and break handling.
module uart_host_rx
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [DIV_W-1:0] div_i,
  input  logic             rx_i,
  output logic [7:0]       rx_data_o,
  output logic             rx_valid_o,
  output logic             rx_ferr_o
);

  localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);

  rx_state_e        state_q;
  logic             sync1_q, sync2_q, prev_q;
  logic [DIV_W-1:0] div_q, timer_q;
  logic [3:0]       bit_cnt_q;
  logic [7:0]       shift_q, data_q;
  logic             valid_q, ferr_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      state_q   <= RX_HUNT;
      div_q     <= '0;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        RX_HUNT: begin
          if (prev_q && !sync2_q) begin
            state_q <= RX_START;
            div_q   <= div_i;
            timer_q <= (div_i >> 1) - ONE;
          end
        end
        RX_START: begin
          if (timer_q != '0) timer_q <= timer_q - ONE;
          else if (sync2_q) state_q <= RX_HUNT;  // start bit too short: glitch
          else begin
            state_q   <= RX_DATA;
            timer_q   <= div_q - ONE;
            bit_cnt_q <= '0;
          end
        end
        RX_DATA: begin
          if (timer_q != '0) timer_q <= timer_q - ONE;
          else begin
            shift_q <= {sync2_q, shift_q[7:1]};
            timer_q <= div_q - ONE;
            if (bit_cnt_q == LAST_DATA) state_q <= RX_STOP;
            else bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end
        RX_STOP: begin
          if (timer_q != '0) timer_q <= timer_q - ONE;
          else begin
            data_q <= shift_q;
            if (sync2_q) begin
              valid_q <= 1'b1;
              state_q <= RX_HUNT;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= RX_BREAK;
            end
          end
        end
        RX_BREAK: begin
          if (sync2_q) state_q <= RX_HUNT;
        end
        default: state_q <= RX_HUNT;
      endcase
    end
  end

  assign rx_data_o  = data_q;
  assign rx_valid_o = valid_q;
  assign rx_ferr_o  = ferr_q;

endmodule

// File: rtl/uart_host.sv
// Host-side UART: idle gap plus calibration character after reset/resync, then fixed-rate 8N1.
module uart_host
  import uart_pkg::*;
#(
  parameter int         DIV_W     = 16,
  parameter logic [7:0] SYNC_BYTE = 8'h55,
  parameter int         SYNC_GAP  = 2
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [DIV_W-1:0] divisor,
  input  logic             resync,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx,
  input  logic             rx,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             rx_ferr,
  output logic             synced
);

  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO      = DIV_W'(2);
  localparam logic [3:0]       STOP_IDX = 4'(FRAME_BITS - 1);
  localparam logic [3:0]       GAP_LAST = 4'(SYNC_GAP - 1);

  tx_state_e        state_q;
  logic             gap_init_q, tx_q, synced_q, resync_pend_q;
  logic [DIV_W-1:0] div_q, timer_q, eff_div;
  logic [3:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic             accept;

  assign eff_div  = (divisor < TWO) ? TWO : divisor;
  assign tx_ready = (state_q == TX_IDLE) ||
                    (state_q == TX_SEND && bit_cnt_q == STOP_IDX && timer_q == '0);
  assign accept   = tx_valid && tx_ready;

  // NOTE: all state uses <= so every branch reads pre-edge values; where two
  // assignments to resync_pend_q occur in one cycle the later one wins.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q       <= TX_GAP;
      gap_init_q    <= 1'b1;
      div_q         <= '0;
      timer_q       <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      tx_q          <= 1'b1;
      synced_q      <= 1'b0;
      resync_pend_q <= 1'b0;
    end else begin
      case (state_q)
        TX_GAP: begin
          tx_q <= 1'b1;
          // First gap clock latches the divisor; it already counts as one bit clock.
          if (gap_init_q) begin
            gap_init_q <= 1'b0;
            div_q      <= eff_div;
            timer_q    <= eff_div - TWO;
            bit_cnt_q  <= '0;
          end else if (timer_q != '0) begin
            timer_q <= timer_q - ONE;
          end else if (bit_cnt_q == GAP_LAST) begin
            state_q   <= TX_SYNC;
            div_q     <= eff_div;
            timer_q   <= eff_div - ONE;
            bit_cnt_q <= '0;
            shift_q   <= SYNC_BYTE;
            tx_q      <= 1'b0;
          end else begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
            timer_q   <= div_q - ONE;
          end
        end
        TX_IDLE: begin
          if (accept) begin
            state_q       <= TX_SEND;
            div_q         <= eff_div;
            timer_q       <= eff_div - ONE;
            bit_cnt_q     <= '0;
            shift_q       <= tx_data;
            tx_q          <= 1'b0;
            resync_pend_q <= resync_pend_q | resync;
          end else if (resync || resync_pend_q) begin
            state_q       <= TX_GAP;
            gap_init_q    <= 1'b1;
            synced_q      <= 1'b0;
            resync_pend_q <= 1'b0;
          end
        end
        default: begin  // TX_SYNC, TX_SEND: shifting a frame
          if (resync && state_q == TX_SEND) resync_pend_q <= 1'b1;
          if (timer_q != '0) begin
            timer_q <= timer_q - ONE;
          end else if (bit_cnt_q != STOP_IDX) begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
            timer_q   <= div_q - ONE;
            tx_q      <= shift_q[0];
            shift_q   <= {1'b1, shift_q[7:1]};  // the shifted-in 1 becomes the stop bit
          end else if (state_q == TX_SYNC) begin
            state_q  <= TX_IDLE;
            synced_q <= 1'b1;
          end else if (accept) begin
            div_q     <= eff_div;
            timer_q   <= eff_div - ONE;
            bit_cnt_q <= '0;
            shift_q   <= tx_data;
            tx_q      <= 1'b0;
          end else if (resync || resync_pend_q) begin
            state_q       <= TX_GAP;
            gap_init_q    <= 1'b1;
            synced_q      <= 1'b0;
            resync_pend_q <= 1'b0;
          end else begin
            state_q <= TX_IDLE;
          end
        end
      endcase
    end
  end

  assign tx     = tx_q;
  assign synced = synced_q;

  uart_host_rx #(.DIV_W(DIV_W)) u_rx (
    .clk       (clk),
    .nreset    (nreset),
    .div_i     (eff_div),
    .rx_i      (rx),
    .rx_data_o (rx_data),
    .rx_valid_o(rx_valid),
    .rx_ferr_o (rx_ferr)
  );

endmodule

// File: tb/tb_uart_host.sv
// Self-checking bench for uart_host: expected tx waveforms are built bit-by-bit from frame rules.
module tb_uart_host;

  localparam int         DIV_W     = 16;
  localparam int         SYNC_GAP  = 2;
  localparam logic [7:0] SYNC_BYTE = 8'h55;

  logic             clk = 1'b0;
  logic             nreset;
  logic [DIV_W-1:0] divisor;
  logic             resync, tx_valid, tx_ready, tx, rx, rx_valid, rx_ferr, synced;
  logic [7:0]       tx_data, rx_data;

  always #5 clk = ~clk;

  uart_host #(.DIV_W(DIV_W), .SYNC_BYTE(SYNC_BYTE), .SYNC_GAP(SYNC_GAP)) dut (
    .clk(clk), .nreset(nreset), .divisor(divisor), .resync(resync),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx(tx),
    .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr),
    .synced(synced)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_valid  = 0;
  int         n_ferr   = 0;
  logic [7:0] last_valid_data = 8'h00;
  logic       exp_q[$];
  logic [7:0] burst_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int eff(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  // Reference line model: idle = 1s, frame = start 0, data LSB first, stop 1.
  function automatic void add_idle(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(1'b1);
  endfunction

  function automatic void add_frame(input logic [7:0] b, input int d);
    logic lvl;
    for (int k = 0; k < 10; k++) begin
      lvl = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      for (int c = 0; c < d; c++) exp_q.push_back(lvl);
    end
  endfunction

  always @(negedge clk) begin
    if (nreset) begin
      if (rx_valid) begin
        n_valid++;
        last_valid_data = rx_data;
      end
      if (rx_ferr) n_ferr++;
      if (rx_valid || rx_ferr) check("rx_exclusive", {31'd0, rx_valid && rx_ferr}, 0);
    end
  end

  task automatic reset_and_sync(input string tag, input int div_in);
    int n;
    nreset = 1'b0; divisor = DIV_W'(div_in); tx_valid = 1'b0; resync = 1'b0; rx = 1'b1;
    repeat (3) step();
    check({tag, "_rst_tx"}, tx, 1);
    check({tag, "_rst_ready"}, tx_ready, 0);
    check({tag, "_rst_synced"}, synced, 0);
    check({tag, "_rst_rxdata"}, rx_data, 0);
    check({tag, "_rst_rxvalid"}, rx_valid, 0);
    check({tag, "_rst_rxferr"}, rx_ferr, 0);
    nreset = 1'b1;
    exp_q.delete();
    add_idle(SYNC_GAP * eff(div_in));
    add_frame(SYNC_BYTE, eff(div_in));
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_tx"}, tx, exp_q[i]);
      if (i == 0 || i == n - 1 || i == n / 2) begin
        check({tag, "_ready_lo"}, tx_ready, 0);
        check({tag, "_synced_lo"}, synced, 0);
      end
      step();
    end
    check({tag, "_synced"}, synced, 1);
    check({tag, "_ready"}, tx_ready, 1);
    check({tag, "_idle_tx"}, tx, 1);
  endtask

  task automatic send_burst(input string tag, input int div_in);
    int d, n, fl, k;
    d = eff(div_in); n = burst_q.size(); fl = 10 * d;
    divisor = DIV_W'(div_in);
    exp_q.delete();
    foreach (burst_q[j]) add_frame(burst_q[j], d);
    tx_data = burst_q[0]; tx_valid = 1'b1;
    check({tag, "_ready_idle"}, tx_ready, 1);
    step();
    if (n > 1) tx_data = burst_q[1];
    else tx_valid = 1'b0;
    for (int i = 0; i < n * fl; i++) begin
      check({tag, "_tx"}, tx, exp_q[i]);
      if (i % fl == fl - 2) check({tag, "_ready_lo"}, tx_ready, 0);
      if (i % fl == fl - 1) check({tag, "_ready_hi"}, tx_ready, 1);
      step();
      if (i % fl == fl - 1) begin
        k = i / fl + 2;
        if (k < n) tx_data = burst_q[k];
        else tx_valid = 1'b0;
      end
    end
    check({tag, "_end_tx"}, tx, 1);
    check({tag, "_end_ready"}, tx_ready, 1);
  endtask

  task automatic rx_send(input logic [7:0] b, input int d, input logic stop_lvl);
    for (int k = 0; k < 10; k++) begin
      rx = (k == 0) ? 1'b0 : (k == 9) ? stop_lvl : b[k-1];
      repeat (d) step();
    end
  endtask

  task automatic rx_expect(input string tag, input logic [7:0] b, input int div_in);
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    divisor = DIV_W'(div_in);
    rx_send(b, eff(div_in), 1'b1);
    rx = 1'b1;
    repeat (6) step();
    check({tag, "_nvalid"}, n_valid - v0, 1);
    check({tag, "_nferr"}, n_ferr - f0, 0);
    check({tag, "_data"}, last_valid_data, b);
    check({tag, "_rxdata"}, rx_data, b);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, f0, n;
    logic [7:0] b;
    tx_data = 8'h00; tx_valid = 1'b0; resync = 1'b0; rx = 1'b1;
    divisor = DIV_W'(16); nreset = 1'b0;

    reset_and_sync("t1", 16);

    burst_q = '{8'hA3, 8'h0F};
    send_burst("t2", 4);
    repeat (3) begin
      burst_q.delete();
      repeat ($urandom_range(1, 4)) burst_q.push_back(8'($urandom));
      send_burst("tx_rand", int'($urandom_range(0, 6)));
    end

    rx_expect("t3", 8'h3C, 8);

    divisor = DIV_W'(8); v0 = n_valid; f0 = n_ferr;
    rx = 1'b0; repeat (3) step();
    rx = 1'b1; repeat (30) step();
    check("t4_glitch_valid", n_valid - v0, 0);
    check("t4_glitch_ferr", n_ferr - f0, 0);
    rx_expect("t4", 8'h5A, 8);

    v0 = n_valid; f0 = n_ferr;
    rx_send(8'h81, 8, 1'b0);
    rx = 1'b0; repeat (40) step();
    check("t5_ferr", n_ferr - f0, 1);
    check("t5_valid", n_valid - v0, 0);
    check("t5_rxdata", rx_data, 8'h81);
    rx = 1'b1; repeat (10) step();
    rx_expect("t5b", 8'h42, 8);

    repeat (6) begin
      b = 8'($urandom);
      rx_expect("rx_rand", b, int'($urandom_range(0, 10)));
      repeat ($urandom_range(0, 5)) step();
    end

    // Resync during SEND: frame completes, then gap and calibration frame.
    divisor = DIV_W'(4); tx_data = 8'h77; tx_valid = 1'b1;
    check("t6_ready", tx_ready, 1);
    step();
    tx_valid = 1'b0;
    exp_q.delete(); add_frame(8'h77, 4); add_idle(SYNC_GAP * 4); add_frame(SYNC_BYTE, 4);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      check("t6_tx", tx, exp_q[i]);
      if (i == 39) check("t6_synced_hi", synced, 1);
      if (i == 40) begin
        check("t6_synced_lo", synced, 0);
        check("t6_ready_lo", tx_ready, 0);
      end
      if (i == 15) resync = 1'b1;
      step();
      resync = 1'b0;
    end
    check("t6_synced", synced, 1);
    check("t6_ready_end", tx_ready, 1);

    // Resync from IDLE: gap starts the next cycle.
    resync = 1'b1;
    step();
    resync = 1'b0;
    exp_q.delete(); add_idle(SYNC_GAP * 4); add_frame(SYNC_BYTE, 4);
    n = exp_q.size();
    check("t6i_synced_lo", synced, 0);
    for (int i = 0; i < n; i++) begin
      check("t6i_tx", tx, exp_q[i]);
      step();
    end
    check("t6i_synced", synced, 1);

    // Reset while a start bit is on the line.
    tx_data = 8'($urandom); tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    step();
    check("t6r_pre_tx", tx, 0);
    nreset = 1'b0;
    #1;
    check("t6r_async_tx", tx, 1);
    reset_and_sync("t6r", 16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
